reg_serializer: RTL and testbench

- Reader end of the parallel register path: accepts an N-bit word over a valid/ready handshake and shifts it out on a single serial line.
- Frame format: start bit (0), N data bits LSB first, stop bit (1); line idles high.
- Sits after the REGn-style holding registers; drives an off-chip serial pin or a downstream deserializer.

---
 rtl/reg_serializer.sv | 116 +++++++++++
 tb/tb_reg_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/reg_serializer.sv
// Parallel-to-serial transmitter: takes an N-bit word over valid/ready and sends
// a start bit (0), N data bits LSB first and a stop bit (1), each held BITCLKS cycles.
module reg_serializer #(
    parameter int N       = 8,
    parameter int BITCLKS = 4
) (
    input  logic         clk,
    input  logic         rest,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] d,
    output logic         sdo,
    output logic         busy,
    output logic         done
);

    localparam int CW = (BITCLKS > 1) ? $clog2(BITCLKS) : 1;
    localparam int BW = $clog2(N) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BITCLKS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic           sdo_q, sdo_d;
    logic           bit_end;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sdo_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sdo_q   <= sdo_d;
        end
    end

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state (and reset), never on in_valid.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        bit_end  = (cnt_q == CNT_LAST);
        in_ready = (state_q == IDLE) && !rest;
        busy     = (state_q != IDLE);
        done     = (state_q == STOP) && bit_end;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shreg_d = d;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // sdo is registered, so it is computed from the state being entered.
        case (state_d)
            START:   sdo_d = 1'b0;
            DATA:    sdo_d = shreg_d[0];
            default: sdo_d = 1'b1;
        endcase
    end

    assign sdo = sdo_q;

endmodule

// File: tb/tb_reg_serializer.sv
// Bench for reg_serializer: directed and random frames compared against an
// expected-bit queue built from the frame format, plus reset and BITCLKS=1 cases.
module tb_reg_serializer;

    localparam int N     = 8;
    localparam int B     = 4;
    localparam int FRAME = (N + 2) * B;

    logic         clk = 1'b0;
    logic         rest;
    logic         in_valid, in_ready, sdo, busy, done;
    logic [N-1:0] d;
    logic         in_valid1, in_ready1, sdo1, busy1, done1;
    logic [N-1:0] d1;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [0:0] exp_q[$];

    reg_serializer #(.N(N), .BITCLKS(B)) u_dut (
        .clk(clk), .rest(rest), .in_valid(in_valid), .in_ready(in_ready),
        .d(d), .sdo(sdo), .busy(busy), .done(done)
    );

    reg_serializer #(.N(N), .BITCLKS(1)) u_dut1 (
        .clk(clk), .rest(rest), .in_valid(in_valid1), .in_ready(in_ready1),
        .d(d1), .sdo(sdo1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Line waveform of one frame, one entry per clock cycle.
    task automatic load_frame(input logic [N-1:0] w, input int bc);
        repeat (bc) exp_q.push_back(1'b0);
        for (int i = 0; i < N; i++)
            repeat (bc) exp_q.push_back(w[i]);
        repeat (bc) exp_q.push_back(1'b1);
    endtask

    // Called just before a rising edge with the DUT idle; returns at the
    // negedge of the first idle cycle after the frame.
    task automatic frame4(input logic [N-1:0] w, input bit keep_valid, input logic [N-1:0] mid_d);
        logic e_bit;
        int   k;
        d        = w;
        in_valid = 1'b1;
        check($sformatf("idle_ready_%02h", w), in_ready, 1);
        check($sformatf("idle_sdo_%02h", w), sdo, 1);
        check($sformatf("idle_busy_%02h", w), busy, 0);
        load_frame(w, B);
        @(posedge clk);
        @(negedge clk);
        k = 0;
        while (exp_q.size() > 0) begin
            if (k == 0 && !keep_valid) in_valid = 1'b0;
            if (k == 1 && !keep_valid) d = N'($urandom_range(0, 255));
            if (k == FRAME / 2 && keep_valid) d = mid_d;
            e_bit = exp_q.pop_front();
            check($sformatf("sdo_%02h[%0d]", w, k), sdo, e_bit);
            check($sformatf("busy_%02h[%0d]", w, k), busy, 1);
            check($sformatf("done_%02h[%0d]", w, k), done, (k == FRAME - 1));
            check($sformatf("ready_%02h[%0d]", w, k), in_ready, 0);
            k++;
            @(negedge clk);
        end
        check($sformatf("end_busy_%02h", w), busy, 0);
        check($sformatf("end_ready_%02h", w), in_ready, 1);
        check($sformatf("end_sdo_%02h", w), sdo, 1);
        check($sformatf("end_done_%02h", w), done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rw, rm;
        bit           rk;
        int           p;

        // Power-up reset with in_valid already high.
        rest      = 1'b1;
        in_valid  = 1'b1;
        d         = 8'hA5;
        in_valid1 = 1'b0;
        d1        = '0;
        #1;
        check("rst_sdo", sdo, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", in_ready, 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_sdo", sdo, 1);
            check("rst_hold_busy", busy, 0);
            check("rst_hold_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        rest     = 1'b0;
        #1;
        check("rel_ready", in_ready, 1);

        frame4(8'hA5, 1'b0, 8'h00);
        frame4(8'h00, 1'b1, 8'hFF);
        frame4(8'hFF, 1'b0, 8'h00);
        frame4(8'h3C, 1'b1, 8'hC3);
        frame4(8'hC3, 1'b0, 8'h00);
        repeat (4) begin
            rw = N'($urandom_range(0, 255));
            rk = 1'($urandom_range(0, 1));
            rm = N'($urandom_range(0, 255));
            frame4(rw, rk, rm);
            if (rk) frame4(rm, 1'b0, 8'h00);
        end

        // BITCLKS=1, continuous in_valid: period of 11 cycles.
        d1        = 8'h81;
        in_valid1 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            load_frame(8'h81, 1);
            exp_q.push_back(1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 33; c++) begin
            p = c % 11;
            check($sformatf("b1_sdo[%0d]", c), sdo1, exp_q.pop_front());
            check($sformatf("b1_busy[%0d]", c), busy1, (p < 10));
            check($sformatf("b1_done[%0d]", c), done1, (p == 9));
            check($sformatf("b1_ready[%0d]", c), in_ready1, (p == 10));
            if (c == 32) in_valid1 = 1'b0;
            @(negedge clk);
        end
        check("b1_end_busy", busy1, 0);
        check("b1_end_sdo", sdo1, 1);

        // Asynchronous reset in the middle of data bit 3 of 8'h5A.
        d        = 8'h5A;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_sdo", sdo, 1);
        #2 rest = 1'b1;
        #1;
        check("mid_rst_sdo", sdo, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ready", in_ready, 0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_hold_done", done, 0);
            check("mid_rst_hold_sdo", sdo, 1);
        end
        rest = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);
        frame4(8'h12, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
